// File: rtl/nmr_bstrm_capture_enc_if.sv
// -----------------------------------------------------------------------------
// nmr_bstrm_capture_enc_if
//
// Word output channel of the bitstream capture encoder. It carries one encoded
// command word (data field plus four mutually exclusive flags) under a
// valid/ready handshake towards the SRAM writer.
//
// Signals
//   data             DATA_WIDTH  run length (run words) or packed bits (pattern)
//   pattern_mode     1           word holds packed bits, LSB = first sample
//   all_1_mode       1           word is a run of ones, data = run length
//   all_0_mode       1           word is a run of zeros, data = run length
//   end_of_sequence  1           terminating word, data = 0
//   WR_VALID         1           word is valid (master -> slave)
//   WR_READY         1           slave accepts the word (slave -> master)
//
// Modports
//   master  the encoder (drives word and WR_VALID)
//   slave   the word consumer (drives WR_READY)
// -----------------------------------------------------------------------------
interface nmr_bstrm_capture_enc_if #(
    parameter int DATA_WIDTH = 120
);
    logic [DATA_WIDTH-1:0] data;
    logic                  pattern_mode;
    logic                  all_1_mode;
    logic                  all_0_mode;
    logic                  end_of_sequence;
    logic                  WR_VALID;
    logic                  WR_READY;

    modport master (
        output data,
        output pattern_mode,
        output all_1_mode,
        output all_0_mode,
        output end_of_sequence,
        output WR_VALID,
        input  WR_READY
    );

    modport slave (
        input  data,
        input  pattern_mode,
        input  all_1_mode,
        input  all_0_mode,
        input  end_of_sequence,
        input  WR_VALID,
        output WR_READY
    );
endinterface

// File: rtl/nmr_bstrm_capture_enc.sv
// -----------------------------------------------------------------------------
// nmr_bstrm_capture_enc
//
// Bitstream capture encoder. Samples a serial bit on every clock while a
// capture is active and compresses the stream into generator command words:
//   - run-length mode: one word per run of equal bits (all_1 / all_0 flag,
//     data = length, saturating at 2^DATA_WIDTH-1 and restarting),
//   - pattern mode: DATA_WIDTH samples packed LSB first into one word.
// On STOP the partial word (if any) is flushed, then an end_of_sequence word
// is emitted and the block returns to idle. Words leave through a single-entry
// output register; a word produced in RUN/PAT while that register is stalled
// is dropped and flagged on the sticky OVERFLOW output.
//
// Ports
//   CLK          in   system clock, rising edge
//   RST_N        in   asynchronous active-low reset
//   START        in   pulse, begins a capture when idle (wins over STOP)
//   STOP         in   pulse, ends the capture (that cycle's IN is not sampled)
//   pattern_sel  in   latched at START: 1 = pattern mode, 0 = run-length mode
//   IN           in   serial bitstream sample
//   wr           master port of nmr_bstrm_capture_enc_if (word + handshake)
//   DONE         out  high while idle
//   OVERFLOW     out  sticky, a word was dropped; cleared by reset or START
// -----------------------------------------------------------------------------
module nmr_bstrm_capture_enc #(
    parameter int DATA_WIDTH = 120
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    START,
    input  logic                    STOP,
    input  logic                    pattern_sel,
    input  logic                    IN,
    nmr_bstrm_capture_enc_if.master wr,
    output logic                    DONE,
    output logic                    OVERFLOW
);
    localparam int                    IDX_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(DATA_WIDTH - 1);
    localparam logic [DATA_WIDTH-1:0] RUN_MAX  = '1;
    localparam logic [DATA_WIDTH-1:0] RUN_ONE  = DATA_WIDTH'(1);

    // Flag vector ordering: {pattern_mode, all_1_mode, all_0_mode, end_of_sequence}
    localparam logic [3:0] FLG_PAT = 4'b1000;
    localparam logic [3:0] FLG_EOS = 4'b0001;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_PAT   = 3'd2,
        S_FLUSH = 3'd3,
        S_EOS   = 3'd4
    } state_t;

    state_t                state_reg, state_next;

    logic [DATA_WIDTH-1:0] run_cnt_reg, run_cnt_next;
    logic                  cur_bit_reg, cur_bit_next;
    logic [IDX_W-1:0]      bit_idx_reg, bit_idx_next;
    logic [DATA_WIDTH-1:0] pack_reg, pack_next;
    logic                  sel_reg, sel_next;
    logic                  overflow_reg, overflow_next;

    // Single-entry output register
    logic [DATA_WIDTH-1:0] word_data_reg;
    logic [3:0]            word_flags_reg;
    logic                  valid_reg;

    logic                  slot_busy;
    logic                  emit;
    logic                  load;
    logic [DATA_WIDTH-1:0] emit_data;
    logic [3:0]            emit_flags;
    logic [3:0]            run_flags;
    logic [DATA_WIDTH-1:0] pat_word;

    // The slot is busy only if its word is not leaving on this edge, so a
    // transfer and a new load can share one edge without a bubble.
    assign slot_busy = valid_reg & ~wr.WR_READY;
    assign load      = emit & ~slot_busy;
    assign run_flags = {1'b0, cur_bit_reg, ~cur_bit_reg, 1'b0};
    // Pack register with the current sample merged in at bit_idx.
    assign pat_word  = pack_reg | ({{(DATA_WIDTH-1){1'b0}}, IN} << bit_idx_reg);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:        if (START)      state_next = pattern_sel ? S_PAT : S_RUN;
            S_RUN, S_PAT:  if (STOP)       state_next = S_FLUSH;
            S_FLUSH:       if (!slot_busy) state_next = S_EOS;
            S_EOS:         if (!slot_busy) state_next = S_IDLE;
            default:                       state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (word emission request and DONE)
    // ------------------------------------------------------------------
    always_comb begin
        emit       = 1'b0;
        emit_data  = '0;
        emit_flags = '0;
        case (state_reg)
            S_RUN: begin
                // A run ends when the bit changes or the count would overflow.
                if (!STOP && (run_cnt_reg != '0) &&
                    ((IN != cur_bit_reg) || (run_cnt_reg == RUN_MAX))) begin
                    emit       = 1'b1;
                    emit_data  = run_cnt_reg;
                    emit_flags = run_flags;
                end
            end
            S_PAT: begin
                if (!STOP && (bit_idx_reg == IDX_LAST)) begin
                    emit       = 1'b1;
                    emit_data  = pat_word;
                    emit_flags = FLG_PAT;
                end
            end
            S_FLUSH: begin
                // Flush waits for a free slot, so it never overflows.
                if (!slot_busy) begin
                    if (sel_reg && (bit_idx_reg != '0)) begin
                        emit       = 1'b1;
                        emit_data  = pack_reg;
                        emit_flags = FLG_PAT;
                    end else if (!sel_reg && (run_cnt_reg != '0)) begin
                        emit       = 1'b1;
                        emit_data  = run_cnt_reg;
                        emit_flags = run_flags;
                    end
                end
            end
            S_EOS: begin
                if (!slot_busy) begin
                    emit       = 1'b1;
                    emit_flags = FLG_EOS;
                end
            end
            default: ;
        endcase
    end

    assign DONE = (state_reg == S_IDLE);

    // ------------------------------------------------------------------
    // Capture datapath: run counter, pattern packer, overflow flag
    // ------------------------------------------------------------------
    always_comb begin
        run_cnt_next  = run_cnt_reg;
        cur_bit_next  = cur_bit_reg;
        bit_idx_next  = bit_idx_reg;
        pack_next     = pack_reg;
        sel_next      = sel_reg;
        overflow_next = overflow_reg;
        case (state_reg)
            S_IDLE: begin
                if (START) begin
                    run_cnt_next  = '0;
                    cur_bit_next  = 1'b0;
                    bit_idx_next  = '0;
                    pack_next     = '0;
                    sel_next      = pattern_sel;
                    overflow_next = 1'b0;
                end
            end
            S_RUN: begin
                if (!STOP) begin
                    // First sample or a just-closed run both start a new run
                    // of length one; a saturated run restarts with the same bit.
                    if ((run_cnt_reg == '0) || emit) begin
                        cur_bit_next = IN;
                        run_cnt_next = RUN_ONE;
                    end else begin
                        run_cnt_next = run_cnt_reg + 1'b1;
                    end
                end
            end
            S_PAT: begin
                if (!STOP) begin
                    if (bit_idx_reg == IDX_LAST) begin
                        pack_next    = '0;
                        bit_idx_next = '0;
                    end else begin
                        pack_next    = pat_word;
                        bit_idx_next = bit_idx_reg + 1'b1;
                    end
                end
            end
            S_FLUSH: begin
                if (!slot_busy) begin
                    run_cnt_next = '0;
                    bit_idx_next = '0;
                    pack_next    = '0;
                end
            end
            default: ;
        endcase
        if (emit && slot_busy) begin
            overflow_next = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            run_cnt_reg  <= '0;
            cur_bit_reg  <= 1'b0;
            bit_idx_reg  <= '0;
            pack_reg     <= '0;
            sel_reg      <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            run_cnt_reg  <= run_cnt_next;
            cur_bit_reg  <= cur_bit_next;
            bit_idx_reg  <= bit_idx_next;
            pack_reg     <= pack_next;
            sel_reg      <= sel_next;
            overflow_reg <= overflow_next;
        end
    end

    assign OVERFLOW = overflow_reg;

    // ------------------------------------------------------------------
    // Output register. A held word stays untouched while stalled; a word
    // that cannot be loaded is simply not written (dropped).
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            word_data_reg  <= '0;
            word_flags_reg <= '0;
            valid_reg      <= 1'b0;
        end else if (load) begin
            word_data_reg  <= emit_data;
            word_flags_reg <= emit_flags;
            valid_reg      <= 1'b1;
        end else if (wr.WR_READY) begin
            valid_reg      <= 1'b0;
        end
    end

    assign wr.data            = word_data_reg;
    assign wr.pattern_mode    = word_flags_reg[3];
    assign wr.all_1_mode      = word_flags_reg[2];
    assign wr.all_0_mode      = word_flags_reg[1];
    assign wr.end_of_sequence = word_flags_reg[0];
    assign wr.WR_VALID        = valid_reg;

endmodule

// File: tb/tb_nmr_bstrm_capture_enc.sv
// -----------------------------------------------------------------------------
// tb_nmr_bstrm_capture_enc
//
// Self-checking bench for nmr_bstrm_capture_enc at DATA_WIDTH = 8. A table of
// short captures with hand-derived words, hand-written corner sequences
// (saturation, back-pressure/overflow, START+STOP, mid-run reset) and random
// captures compared against a run-length / chunking reference model.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_nmr_bstrm_capture_enc;
    localparam int DW     = 8;
    localparam int MAXRUN = (1 << DW) - 1;

    // Flags: {pattern_mode, all_1_mode, all_0_mode, end_of_sequence}
    localparam logic [3:0] F_PAT = 4'b1000;
    localparam logic [3:0] F_A1  = 4'b0100;
    localparam logic [3:0] F_A0  = 4'b0010;
    localparam logic [3:0] F_EOS = 4'b0001;

    typedef struct packed {
        logic [3:0]    flags;
        logic [DW-1:0] data;
    } word_t;

    typedef struct packed {
        logic        sel;
        logic [7:0]  len;
        logic [31:0] bits;   // bit k is the k-th sample
        logic [1:0]  n_exp;  // words expected before end_of_sequence
        word_t       e0;
        word_t       e1;
        word_t       e2;
    } vec_t;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    logic START = 1'b0;
    logic STOP = 1'b0;
    logic pattern_sel = 1'b0;
    logic IN = 1'b0;
    logic DONE;
    logic OVERFLOW;

    nmr_bstrm_capture_enc_if #(.DATA_WIDTH(DW)) wr_if ();

    nmr_bstrm_capture_enc #(.DATA_WIDTH(DW)) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .START       (START),
        .STOP        (STOP),
        .pattern_sel (pattern_sel),
        .IN          (IN),
        .wr          (wr_if),
        .DONE        (DONE),
        .OVERFLOW    (OVERFLOW)
    );

    always #5 CLK = ~CLK;

    int    n_checks = 0;
    int    n_errors = 0;
    word_t cap_q[$];
    word_t exp_q[$];
    bit    stim_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic word_t mkw(input logic [3:0] f, input int d);
        word_t w;
        w.flags = f;
        w.data  = DW'(d);
        return w;
    endfunction

    function automatic vec_t mkv(input bit sel, input int len, input logic [31:0] bits,
                                 input int n, input word_t e0, input word_t e1, input word_t e2);
        vec_t v;
        v.sel   = sel;
        v.len   = 8'(len);
        v.bits  = bits;
        v.n_exp = 2'(n);
        v.e0    = e0;
        v.e1    = e1;
        v.e2    = e2;
        return v;
    endfunction

    // Reference model: words a capture of stim_q should produce.
    function automatic void build_expected(input bit sel);
        int            n;
        int            i;
        int            len;
        int            chunk;
        bit            b;
        logic [DW-1:0] v;
        n = stim_q.size();
        i = 0;
        exp_q.delete();
        if (sel) begin
            for (int base = 0; base < n; base += DW) begin
                v = '0;
                for (int j = 0; j < DW && base + j < n; j++) v[j] = stim_q[base + j];
                exp_q.push_back(mkw(F_PAT, int'(v)));
            end
        end else begin
            while (i < n) begin
                b   = stim_q[i];
                len = 0;
                while (i < n && stim_q[i] == b) begin
                    len++;
                    i++;
                end
                while (len > 0) begin
                    chunk = (len > MAXRUN) ? MAXRUN : len;
                    exp_q.push_back(mkw(b ? F_A1 : F_A0, chunk));
                    len -= chunk;
                end
            end
        end
        exp_q.push_back(mkw(F_EOS, 0));
    endfunction

    // Monitor: collect transferred words, check flag one-hotness and stability.
    word_t held_word;
    bit    stalled = 1'b0;
    always @(negedge CLK) begin
        word_t cur;
        cur = {wr_if.pattern_mode, wr_if.all_1_mode, wr_if.all_0_mode,
               wr_if.end_of_sequence, wr_if.data};
        if (!RST_N) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("hold_valid", wr_if.WR_VALID, 1);
                check("hold_word", cur, held_word);
            end
            if (wr_if.WR_VALID) begin
                check("flag_onehot", $countones(cur.flags), 1);
                if (wr_if.WR_READY) cap_q.push_back(cur);
            end
            stalled   = wr_if.WR_VALID && !wr_if.WR_READY;
            held_word = cur;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_cap(input bit sel, input bit with_stop);
        START       = 1'b1;
        pattern_sel = sel;
        STOP        = with_stop;
        tick();
        START       = 1'b0;
        STOP        = 1'b0;
        pattern_sel = 1'b0;
    endtask

    task automatic feed();
        for (int i = 0; i < stim_q.size(); i++) begin
            IN = stim_q[i];
            tick();
        end
    endtask

    task automatic stop_cap();
        STOP = 1'b1;
        IN   = 1'($urandom_range(0, 1));  // not sampled on the STOP cycle
        tick();
        STOP = 1'b0;
    endtask

    task automatic drain(input bit rand_ready, input string name);
        int c;
        c = 0;
        while (!(DONE && !wr_if.WR_VALID) && c < 60) begin
            wr_if.WR_READY = (rand_ready && c < 40) ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            c++;
        end
        wr_if.WR_READY = 1'b1;
        check({name, "_drained"}, DONE && !wr_if.WR_VALID, 1);
    endtask

    task automatic compare_words(input string name);
        check({name, "_count"}, cap_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
            check($sformatf("%s_w%0d", name, i), cap_q[i], exp_q[i]);
    endtask

    // Full capture of stim_q against exp_q.
    task automatic run_capture(input bit sel, input bit rand_ready, input string name);
        cap_q.delete();
        wr_if.WR_READY = 1'b1;
        start_cap(sel, 1'b0);
        check({name, "_busy"}, DONE, 0);
        feed();
        stop_cap();
        if (!rand_ready) begin
            tick();
            check({name, "_done_lo"}, DONE, 0);
            tick();
            check({name, "_done_hi"}, DONE, 1);
        end
        drain(rand_ready, name);
        compare_words(name);
        check({name, "_ovf"}, OVERFLOW, 0);
    endtask

    vec_t  vecs[8];
    vec_t  v;
    bit    rsel;
    bit    rb;
    int    target;
    int    maxrun;
    int    rr;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vecs[0] = mkv(0, 5,  32'h18,  2, mkw(F_A0, 3),     mkw(F_A1, 2),  mkw(0, 0));
        vecs[1] = mkv(1, 10, 32'h38D, 2, mkw(F_PAT, 'h8D), mkw(F_PAT, 3), mkw(0, 0));
        vecs[2] = mkv(0, 0,  32'h0,   0, mkw(0, 0),        mkw(0, 0),     mkw(0, 0));
        vecs[3] = mkv(1, 8,  32'hA5,  1, mkw(F_PAT, 'hA5), mkw(0, 0),     mkw(0, 0));
        vecs[4] = mkv(1, 0,  32'h0,   0, mkw(0, 0),        mkw(0, 0),     mkw(0, 0));
        vecs[5] = mkv(0, 1,  32'h1,   1, mkw(F_A1, 1),     mkw(0, 0),     mkw(0, 0));
        vecs[6] = mkv(0, 3,  32'h5,   3, mkw(F_A1, 1),     mkw(F_A0, 1),  mkw(F_A1, 1));
        vecs[7] = mkv(1, 9,  32'h1FF, 2, mkw(F_PAT, 'hFF), mkw(F_PAT, 1), mkw(0, 0));

        wr_if.WR_READY = 1'b1;
        RST_N = 1'b0;
        tick();
        tick();
        check("rst_done", DONE, 1);
        check("rst_valid", wr_if.WR_VALID, 0);
        check("rst_ovf", OVERFLOW, 0);
        check("rst_data", wr_if.data, 0);
        RST_N = 1'b1;
        tick();

        // STOP alone in idle is ignored.
        STOP = 1'b1;
        tick();
        STOP = 1'b0;
        tick();
        check("idle_stop_done", DONE, 1);
        check("idle_stop_valid", wr_if.WR_VALID, 0);

        // Table-driven captures.
        for (int t = 0; t < 8; t++) begin
            v = vecs[t];
            stim_q.delete();
            for (int k = 0; k < int'(v.len); k++) stim_q.push_back(v.bits[k]);
            exp_q.delete();
            if (v.n_exp > 0) exp_q.push_back(v.e0);
            if (v.n_exp > 1) exp_q.push_back(v.e1);
            if (v.n_exp > 2) exp_q.push_back(v.e2);
            exp_q.push_back(mkw(F_EOS, 0));
            run_capture(v.sel, 1'b0, $sformatf("vec%0d", t));
        end

        // Saturation: 300 ones.
        stim_q.delete();
        for (int k = 0; k < 300; k++) stim_q.push_back(1'b1);
        exp_q.delete();
        exp_q.push_back(mkw(F_A1, 255));
        exp_q.push_back(mkw(F_A1, 45));
        exp_q.push_back(mkw(F_EOS, 0));
        run_capture(1'b0, 1'b0, "sat300");

        // Back-pressure: first word held, later words dropped.
        cap_q.delete();
        wr_if.WR_READY = 1'b0;
        start_cap(1'b0, 1'b0);
        IN = 1'b0; tick();
        IN = 1'b1; tick();
        check("ovf_first_valid", wr_if.WR_VALID, 1);
        check("ovf_first_word",
              {wr_if.pattern_mode, wr_if.all_1_mode, wr_if.all_0_mode, wr_if.end_of_sequence, wr_if.data},
              mkw(F_A0, 1));
        check("ovf_clear_yet", OVERFLOW, 0);
        IN = 1'b0; tick();
        IN = 1'b1; tick();
        check("ovf_set", OVERFLOW, 1);
        check("ovf_held_word",
              {wr_if.pattern_mode, wr_if.all_1_mode, wr_if.all_0_mode, wr_if.end_of_sequence, wr_if.data},
              mkw(F_A0, 1));
        wr_if.WR_READY = 1'b1;
        stop_cap();
        drain(1'b0, "ovf");
        exp_q.delete();
        exp_q.push_back(mkw(F_A0, 1));
        exp_q.push_back(mkw(F_A1, 1));
        exp_q.push_back(mkw(F_EOS, 0));
        compare_words("ovf");
        check("ovf_sticky", OVERFLOW, 1);
        // START clears OVERFLOW; STOP right after START gives only end_of_sequence.
        cap_q.delete();
        start_cap(1'b0, 1'b0);
        check("ovf_cleared_by_start", OVERFLOW, 0);
        stop_cap();
        drain(1'b0, "startstop");
        exp_q.delete();
        exp_q.push_back(mkw(F_EOS, 0));
        compare_words("startstop");

        // START and STOP in the same idle cycle: capture starts.
        cap_q.delete();
        start_cap(1'b0, 1'b1);
        check("same_cycle_busy", DONE, 0);
        IN = 1'b1; tick();
        IN = 1'b1; tick();
        stop_cap();
        drain(1'b0, "same_cycle");
        exp_q.delete();
        exp_q.push_back(mkw(F_A1, 2));
        exp_q.push_back(mkw(F_EOS, 0));
        compare_words("same_cycle");

        // Reset mid-run with a held word and OVERFLOW set.
        cap_q.delete();
        wr_if.WR_READY = 1'b0;
        start_cap(1'b0, 1'b0);
        IN = 1'b0; tick();
        IN = 1'b1; tick();
        IN = 1'b0; tick();
        check("pre_rst_valid", wr_if.WR_VALID, 1);
        check("pre_rst_ovf", OVERFLOW, 1);
        RST_N = 1'b0;
        #1;
        check("mid_rst_valid", wr_if.WR_VALID, 0);
        check("mid_rst_ovf", OVERFLOW, 0);
        check("mid_rst_done", DONE, 1);
        check("mid_rst_word",
              {wr_if.pattern_mode, wr_if.all_1_mode, wr_if.all_0_mode, wr_if.end_of_sequence, wr_if.data},
              0);
        tick();
        RST_N = 1'b1;
        wr_if.WR_READY = 1'b1;
        tick();
        check("post_rst_capture_count", cap_q.size(), 0);
        stim_q.delete();
        stim_q.push_back(1'b1);
        stim_q.push_back(1'b1);
        stim_q.push_back(1'b1);
        exp_q.delete();
        exp_q.push_back(mkw(F_A1, 3));
        exp_q.push_back(mkw(F_EOS, 0));
        run_capture(1'b0, 1'b0, "post_rst");

        // Random captures against the reference model, random WR_READY after STOP.
        for (int it = 0; it < 16; it++) begin
            rsel   = 1'($urandom_range(0, 1));
            target = (it == 15) ? 600 : int'($urandom_range(0, 60));
            maxrun = (it >= 14) ? 300 : 12;
            stim_q.delete();
            while (stim_q.size() < target) begin
                rb = 1'($urandom_range(0, 1));
                rr = int'($urandom_range(1, maxrun));
                for (int k = 0; k < rr && stim_q.size() < target; k++) stim_q.push_back(rb);
            end
            build_expected(rsel);
            run_capture(rsel, 1'b1, $sformatf("rnd%0d", it));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
